// File: rtl/ebr_block_reader.sv
// rtl/ebr_block_reader.sv - reads an 8-row EBR stripe in 8x8 block order and streams the pixels out
// The EBR output register acts as the first FIFO slot, so out_valid follows the read after one clock.
module ebr_block_reader #(
  parameter int IMAGE_WIDTH = 320,
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_block_last,
  output logic                  out_last
);

  localparam int NBLK = IMAGE_WIDTH / 8;
  localparam int BW   = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam int PW   = DATA_WIDTH + 2;

  if ((IMAGE_WIDTH < 8) || (IMAGE_WIDTH % 8 != 0) ||
      ((64'd1 << ADDR_WIDTH) < 64'(8 * IMAGE_WIDTH))) begin : g_bad_params
    $error("ebr_block_reader: IMAGE_WIDTH must be a multiple of 8 that fits the EBR address space");
  end

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  state_t                r_state;
  state_t                w_next_state;

  logic [BW-1:0]         r_blk;
  logic [2:0]            r_row;
  logic [2:0]            r_col;
  logic [ADDR_WIDTH-1:0] r_raddr;
  logic                  r_s1;
  logic [1:0]            r_s1_tag;
  logic                  r_s2;
  logic [1:0]            r_s2_tag;
  logic [PW-1:0]         r_mem [2];
  logic                  r_rd_ptr;
  logic                  r_wr_ptr;
  logic [1:0]            r_count;

  logic                  w_blk_last;
  logic                  w_block_end;
  logic                  w_final;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_fifo_nonempty;
  logic                  w_out_valid;
  logic [PW-1:0]         w_head;
  logic                  w_pop;
  logic                  w_fifo_pop;
  logic                  w_push;
  logic [2:0]            w_total;
  logic [2:0]            w_limit;
  logic                  w_room;
  logic                  w_issue;

  assign w_blk_last  = (r_blk == BW'(NBLK - 1));
  assign w_block_end = (r_row == 3'd7) && (r_col == 3'd7);
  assign w_final     = w_block_end && w_blk_last;
  assign w_addr      = ADDR_WIDTH'(r_row) * ADDR_WIDTH'(IMAGE_WIDTH)
                     + ADDR_WIDTH'({r_blk, 3'b000}) + ADDR_WIDTH'(r_col);

  // Head is the oldest FIFO entry, or the EBR output directly when the FIFO is empty.
  assign w_fifo_nonempty = (r_count != 2'd0);
  assign w_out_valid     = w_fifo_nonempty || r_s2;
  assign w_head          = w_fifo_nonempty ? r_mem[r_rd_ptr] : {r_s2_tag, rdata};
  assign w_pop           = w_out_valid && out_ready;
  assign w_fifo_pop      = w_pop && w_fifo_nonempty;
  assign w_push          = r_s2 && !(w_pop && !w_fifo_nonempty);

  // Outstanding work (FIFO + address stage + data stage) never exceeds two beats.
  assign w_total = {1'b0, r_count} + {2'b00, r_s1} + {2'b00, r_s2};
  assign w_limit = 3'd2 + {2'b00, w_pop};
  assign w_room  = (w_total < w_limit);

  assign raddr          = r_raddr;
  assign out_valid      = w_out_valid;
  assign out_data       = w_out_valid ? w_head[DATA_WIDTH-1:0] : '0;
  assign out_block_last = w_out_valid && w_head[DATA_WIDTH];
  assign out_last       = w_out_valid && w_head[DATA_WIDTH+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_READ;
      S_READ:  if (w_issue && w_final) w_next_state = S_DRAIN;
      S_DRAIN: if (done) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (r_state != S_IDLE);
    w_issue = 1'b0;
    done    = w_pop && w_head[DATA_WIDTH+1];
    case (r_state)
      S_IDLE:  w_issue = start;
      S_READ:  w_issue = w_room;
      default: w_issue = 1'b0;
    endcase
  end

  // Counters wrap to zero after the final read, so IDLE always starts from blk=row=col=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blk    <= '0;
      r_row    <= '0;
      r_col    <= '0;
      r_raddr  <= '0;
      r_s1     <= 1'b0;
      r_s1_tag <= '0;
      r_s2     <= 1'b0;
      r_s2_tag <= '0;
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_issue) begin
        r_raddr  <= w_addr;
        r_s1_tag <= {w_final, w_block_end};
        if (r_col == 3'd7) begin
          r_col <= '0;
          if (r_row == 3'd7) begin
            r_row <= '0;
            r_blk <= w_blk_last ? '0 : r_blk + 1'b1;
          end else begin
            r_row <= r_row + 3'd1;
          end
        end else begin
          r_col <= r_col + 3'd1;
        end
      end
      r_s1     <= w_issue;
      r_s2     <= r_s1;
      r_s2_tag <= r_s1_tag;
      if (w_push) begin
        r_mem[r_wr_ptr] <= {r_s2_tag, rdata};
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_fifo_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_fifo_pop};
    end
  end

endmodule

// File: tb/tb_ebr_block_reader.sv
// tb/tb_ebr_block_reader.sv - scoreboard bench for ebr_block_reader at IMAGE_WIDTH 16 and 320
module tb_ebr_block_reader;

  localparam int W16  = 16;
  localparam int W320 = 320;
  localparam int AW   = 12;
  localparam int DW   = 8;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          bl;
    logic          l;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start16, start320;
  logic          busy16, busy320, done16, done320;
  logic [AW-1:0] raddr16, raddr320;
  logic [DW-1:0] rdata16, rdata320, data16, data320;
  logic          valid16, valid320, ready16, ready320;
  logic          blast16, blast320, last16, last320;

  logic [DW-1:0] mem16  [2**AW];
  logic [DW-1:0] mem320 [2**AW];

  ebr_block_reader #(.IMAGE_WIDTH(W16), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .busy(busy16), .done(done16),
    .raddr(raddr16), .rdata(rdata16), .out_data(data16), .out_valid(valid16),
    .out_ready(ready16), .out_block_last(blast16), .out_last(last16)
  );

  ebr_block_reader #(.IMAGE_WIDTH(W320), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut320 (
    .clk(clk), .rst_n(rst_n), .start(start320), .busy(busy320), .done(done320),
    .raddr(raddr320), .rdata(rdata320), .out_data(data320), .out_valid(valid320),
    .out_ready(ready320), .out_block_last(blast320), .out_last(last320)
  );

  always @(posedge clk) rdata16  <= mem16[raddr16];
  always @(posedge clk) rdata320 <= mem320[raddr320];

  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    beats16, dones16, done_cyc16, beats320, dones320, done_cyc320;
  int    mode16 = 0;
  beat_t q16[$];
  beat_t q320[$];
  logic          hold16 = 1'b0;
  logic [DW-1:0] held16 = '0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: beat n belongs to block n/64, row (n%64)/8, column n%8.
  task automatic push_stripe(input int w, input bit big);
    beat_t b;
    int    blk, rem, a;
    for (int n = 0; n < 8 * w; n++) begin
      blk  = n / 64;
      rem  = n % 64;
      a    = (rem / 8) * w + blk * 8 + (rem % 8);
      b.d  = big ? mem320[a] : mem16[a];
      b.bl = (rem == 63);
      b.l  = (n == 8 * w - 1);
      if (big) q320.push_back(b);
      else     q16.push_back(b);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      case (mode16)
        0:       ready16 = 1'b1;
        1:       ready16 = (ph % 4 == 0) || (ph % 4 == 3);
        2:       ready16 = 1'($urandom % 2);
        default: ready16 = 1'b0;
      endcase
      ph++;
    end
  end

  always @(negedge clk) begin
    beat_t e;
    if (hold16) begin
      check("hold_valid16", valid16, 1);
      check("hold_data16", data16, held16);
    end
    if (valid16 && ready16) begin
      beats16++;
      if (q16.size() == 0) begin
        check("extra_beat16", 1, 0);
      end else begin
        e = q16.pop_front();
        check("data16", data16, e.d);
        check("block_last16", blast16, e.bl);
        check("last16", last16, e.l);
        check("done16", done16, e.l);
      end
      if (done16) begin
        dones16++;
        done_cyc16 = cyc;
      end
    end else if (done16) begin
      check("stray_done16", 1, 0);
    end
    hold16 = valid16 && !ready16;
    held16 = data16;
  end

  always @(negedge clk) begin
    beat_t e;
    if (valid320 && ready320) begin
      beats320++;
      if (q320.size() == 0) begin
        check("extra_beat320", 1, 0);
      end else begin
        e = q320.pop_front();
        check("data320", data320, e.d);
        check("block_last320", blast320, e.bl);
        check("last320", last320, e.l);
        check("done320", done320, e.l);
      end
      if (done320) begin
        dones320++;
        done_cyc320 = cyc;
      end
    end
  end

  task automatic pulse16(output int st);
    @(posedge clk);
    #1 start16 = 1'b1;
    @(posedge clk);
    #1 start16 = 1'b0;
    st = cyc;
  endtask

  task automatic finish16(input string tag, input int limit);
    int n;
    n = 0;
    while (dones16 == 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    check({tag, "_done_seen"}, dones16, 1);
    repeat (20) @(posedge clk);
    #1;
    check({tag, "_beats"}, beats16, 8 * W16);
    check({tag, "_done_count"}, dones16, 1);
    check({tag, "_queue_left"}, q16.size(), 0);
    check({tag, "_busy_after"}, busy16, 0);
  endtask

  initial begin
    int st, n;
    rst_n = 1'b0; start16 = 1'b0; start320 = 1'b0; ready320 = 1'b1;
    beats16 = 0; dones16 = 0; done_cyc16 = 0; beats320 = 0; dones320 = 0; done_cyc320 = 0;
    for (int a = 0; a < 2**AW; a++) begin
      mem16[a]  = DW'($urandom);
      mem320[a] = DW'($urandom);
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy16, 0);
    check("rst_done", done16, 0);
    check("rst_valid", valid16, 0);
    check("rst_block_last", blast16, 0);
    check("rst_last", last16, 0);
    check("rst_raddr", raddr16, 0);
    check("rst_data", data16, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 1: streaming with ready high, latency and completion time
    mode16 = 0;
    push_stripe(W16, 1'b0);
    pulse16(st);
    check("t1_busy_c1", busy16, 1);
    check("t1_raddr_c1", raddr16, 0);
    check("t1_valid_c1", valid16, 0);
    @(posedge clk);
    #1;
    check("t1_valid_c2", valid16, 1);
    check("t1_data_c2", data16, mem16[0]);
    finish16("t1", 400);
    check("t1_done_latency", done_cyc16 - st + 1, 8 * W16 + 1);

    // 2: ready toggling 1,0,0,1
    beats16 = 0; dones16 = 0; mode16 = 1;
    push_stripe(W16, 1'b0);
    pulse16(st);
    finish16("t2", 1000);

    // 3: ready held low after start, then released
    beats16 = 0; dones16 = 0; mode16 = 3;
    repeat (2) @(posedge clk);
    push_stripe(W16, 1'b0);
    pulse16(st);
    repeat (20) @(posedge clk);
    #1;
    check("t3_raddr_stall", raddr16, 1);
    check("t3_valid_stall", valid16, 1);
    check("t3_data_stall", data16, mem16[0]);
    check("t3_busy_stall", busy16, 1);
    mode16 = 0;
    finish16("t3", 400);

    // 4: second start while busy is ignored
    beats16 = 0; dones16 = 0; mode16 = 2;
    push_stripe(W16, 1'b0);
    pulse16(st);
    n = 0;
    while (beats16 < 40 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check("t4_reached_40", beats16 >= 40, 1);
    pulse16(st);
    check("t4_busy_restart", busy16, 1);
    finish16("t4", 2000);

    // 5: asynchronous reset mid-stripe, then a clean restart
    beats16 = 0; dones16 = 0; mode16 = 0;
    push_stripe(W16, 1'b0);
    pulse16(st);
    n = 0;
    while (beats16 < 70 && n < 400) begin
      @(posedge clk);
      n++;
    end
    check("t5_reached_70", beats16 >= 70, 1);
    #3 rst_n = 1'b0;
    #1;
    check("t5_async_busy", busy16, 0);
    check("t5_async_valid", valid16, 0);
    check("t5_async_data", data16, 0);
    check("t5_async_raddr", raddr16, 0);
    check("t5_async_last", last16 | blast16 | done16, 0);
    q16.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    beats16 = 0; dones16 = 0;
    push_stripe(W16, 1'b0);
    pulse16(st);
    check("t5_restart_raddr", raddr16, 0);
    finish16("t5", 400);

    // 6: default width, full-rate stripe
    push_stripe(W320, 1'b1);
    @(posedge clk);
    #1 start320 = 1'b1;
    @(posedge clk);
    #1 start320 = 1'b0;
    st = cyc;
    n = 0;
    while (dones320 == 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check("t6_done_seen", dones320, 1);
    check("t6_done_latency", done_cyc320 - st + 1, 8 * W320 + 1);
    repeat (5) @(posedge clk);
    #1;
    check("t6_beats", beats320, 8 * W320);
    check("t6_queue_left", q320.size(), 0);
    check("t6_final_raddr", raddr320, 7 * W320 + W320 - 1);
    check("t6_busy_after", busy320, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
